// File: rtl/rf_wb_queue.sv
// In-order writeback queue in front of the register file write port.
// Drains one entry per cycle and exposes two pending-write lookup ports.
module rf_wb_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enq_valid,
    output logic        enq_ready,
    input  logic [4:0]  enq_reg,
    input  logic [31:0] enq_data,
    input  logic        rf_ready,
    output logic        reg_write,
    output logic [4:0]  wr_reg,
    output logic [31:0] wr_data,
    input  logic [4:0]  q_reg1,
    input  logic [4:0]  q_reg2,
    output logic        hit1,
    output logic        hit2,
    output logic [31:0] fwd1,
    output logic [31:0] fwd2,
    output logic        empty
);

    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [PTR_W:0]         count_q, count_d;
    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [DEPTH-1:0][4:0]  reg_q, reg_d;
    logic [DEPTH-1:0][31:0] data_q, data_d;
    logic [PTR_W-1:0]       lk_idx;
    logic                   full;
    logic                   push;
    logic                   pop;

    assign full      = (count_q == (PTR_W+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign enq_ready = !full;
    assign reg_write = !empty && rf_ready;
    assign wr_reg    = empty ? 5'd0  : reg_q[head_q];
    assign wr_data   = empty ? 32'd0 : data_q[head_q];

    // Writes to x0 complete the handshake but are dropped here.
    assign pop  = reg_write;
    assign push = enq_valid && enq_ready && (enq_reg != 5'd0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        reg_d   = reg_q;
        data_d  = data_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        // Push and pop never share a slot: head==tail only when empty or full.
        if (push) begin
            valid_d[tail_q] = 1'b1;
            reg_d[tail_q]   = enq_reg;
            data_d[tail_q]  = enq_data;
            tail_d          = tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Scan oldest to youngest so the last match leaves the youngest value.
    always_comb begin
        hit1   = 1'b0;
        hit2   = 1'b0;
        fwd1   = 32'd0;
        fwd2   = 32'd0;
        lk_idx = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = head_q + PTR_W'(i);
            if (valid_q[lk_idx] && (q_reg1 != 5'd0) && (reg_q[lk_idx] == q_reg1)) begin
                hit1 = 1'b1;
                fwd1 = data_q[lk_idx];
            end
            if (valid_q[lk_idx] && (q_reg2 != 5'd0) && (reg_q[lk_idx] == q_reg2)) begin
                hit2 = 1'b1;
                fwd2 = data_q[lk_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload needs no reset; valid bits gate every use of it.
    always_ff @(posedge clk) begin
        reg_q  <= reg_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_rf_wb_queue.sv
// Directed bench for rf_wb_queue: vector table plus a wrap-around sequence
// checked against a small FIFO model.
module tb_rf_wb_queue;

    logic        clk;
    logic        rst;
    logic        enq_valid;
    logic        enq_ready;
    logic [4:0]  enq_reg;
    logic [31:0] enq_data;
    logic        rf_ready;
    logic        reg_write;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic [4:0]  q_reg1;
    logic [4:0]  q_reg2;
    logic        hit1;
    logic        hit2;
    logic [31:0] fwd1;
    logic [31:0] fwd2;
    logic        empty;

    int checks   = 0;
    int failures = 0;

    rf_wb_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_reg(enq_reg), .enq_data(enq_data),
        .rf_ready(rf_ready), .reg_write(reg_write),
        .wr_reg(wr_reg), .wr_data(wr_data),
        .q_reg1(q_reg1), .q_reg2(q_reg2),
        .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
        .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp packs {enq_ready, reg_write, wr_reg, wr_data, hit1, hit2, fwd1, fwd2, empty}
    typedef struct {
        logic         rst;
        logic         ev;
        logic [4:0]   er;
        logic [31:0]  ed;
        logic         rf;
        logic [4:0]   q1;
        logic [4:0]   q2;
        logic [105:0] exp;
    } vec_t;

    vec_t vecs[$];
    logic [36:0] mq[$];

    function automatic vec_t mk(
        input logic rs, input logic ev, input logic [4:0] er, input logic [31:0] ed,
        input logic rf, input logic [4:0] q1, input logic [4:0] q2,
        input logic rdy, input logic rw, input logic [4:0] wreg, input logic [31:0] wdata,
        input logic h1, input logic h2, input logic [31:0] f1, input logic [31:0] f2,
        input logic e);
        vec_t v;
        v.rst = rs; v.ev = ev; v.er = er; v.ed = ed; v.rf = rf; v.q1 = q1; v.q2 = q2;
        v.exp = {rdy, rw, wreg, wdata, h1, h2, f1, f2, e};
        return v;
    endfunction

    function automatic logic [105:0] outs();
        return {enq_ready, reg_write, wr_reg, wr_data, hit1, hit2, fwd1, fwd2, empty};
    endfunction

    task automatic chk(input string name, input logic [105:0] act, input logic [105:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic ev, input logic [4:0] er,
                         input logic [31:0] ed, input logic rf,
                         input logic [4:0] q1, input logic [4:0] q2);
        rst = rs; enq_valid = ev; enq_reg = er; enq_data = ed;
        rf_ready = rf; q_reg1 = q1; q_reg2 = q2;
    endtask

    initial begin
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        repeat (2) @(negedge clk);

        // reset state, then single enqueue with immediate drain
        vecs.push_back(mk(0,0, 0, 0,     0, 0,0,  1,0, 0, 0,    0,0, 0, 0, 1));
        vecs.push_back(mk(0,1, 5, 'hAA,  1, 0,0,  1,0, 0, 0,    0,0, 0, 0, 1));
        vecs.push_back(mk(0,0, 0, 0,     1, 5,0,  1,1, 5, 'hAA, 1,0, 'hAA, 0, 0));
        vecs.push_back(mk(0,0, 0, 0,     1, 5,0,  1,0, 0, 0,    0,0, 0, 0, 1));
        // fill to full, hold a 5th request, then drain in order
        vecs.push_back(mk(0,1, 1, 'h11,  0, 0,0,  1,0, 0, 0,    0,0, 0, 0, 1));
        vecs.push_back(mk(0,1, 2, 'h22,  0, 0,0,  1,0, 1, 'h11, 0,0, 0, 0, 0));
        vecs.push_back(mk(0,1, 3, 'h33,  0, 0,0,  1,0, 1, 'h11, 0,0, 0, 0, 0));
        vecs.push_back(mk(0,1, 4, 'h44,  0, 0,0,  1,0, 1, 'h11, 0,0, 0, 0, 0));
        vecs.push_back(mk(0,1, 6, 'h66,  0, 6,4,  0,0, 1, 'h11, 0,1, 0, 'h44, 0));
        vecs.push_back(mk(0,1, 6, 'h66,  1, 6,0,  0,1, 1, 'h11, 0,0, 0, 0, 0));
        vecs.push_back(mk(0,0, 0, 0,     1, 0,0,  1,1, 2, 'h22, 0,0, 0, 0, 0));
        vecs.push_back(mk(0,0, 0, 0,     1, 0,0,  1,1, 3, 'h33, 0,0, 0, 0, 0));
        vecs.push_back(mk(0,0, 0, 0,     1, 0,0,  1,1, 4, 'h44, 0,0, 0, 0, 0));
        vecs.push_back(mk(0,0, 0, 0,     1, 0,0,  1,0, 0, 0,    0,0, 0, 0, 1));
        // duplicate destination: youngest forwarded, both drained in order
        vecs.push_back(mk(0,1, 7, 'hA,   0, 0,0,  1,0, 0, 0,    0,0, 0, 0, 1));
        vecs.push_back(mk(0,1, 7, 'hB,   0, 0,0,  1,0, 7, 'hA,  0,0, 0, 0, 0));
        vecs.push_back(mk(0,1, 3, 'hC,   0, 0,0,  1,0, 7, 'hA,  0,0, 0, 0, 0));
        vecs.push_back(mk(0,0, 0, 0,     0, 7,0,  1,0, 7, 'hA,  1,0, 'hB, 0, 0));
        vecs.push_back(mk(0,0, 0, 0,     1, 7,3,  1,1, 7, 'hA,  1,1, 'hB, 'hC, 0));
        vecs.push_back(mk(0,0, 0, 0,     1, 7,3,  1,1, 7, 'hB,  1,1, 'hB, 'hC, 0));
        vecs.push_back(mk(0,0, 0, 0,     1, 7,3,  1,1, 3, 'hC,  0,1, 0, 'hC, 0));
        vecs.push_back(mk(0,0, 0, 0,     1, 7,3,  1,0, 0, 0,    0,0, 0, 0, 1));
        // write to x0 is accepted and dropped
        vecs.push_back(mk(0,1, 0, 'hDEAD,1, 0,0,  1,0, 0, 0,    0,0, 0, 0, 1));
        vecs.push_back(mk(0,0, 0, 0,     1, 0,0,  1,0, 0, 0,    0,0, 0, 0, 1));
        // reset with 3 entries queued and an enqueue pending
        vecs.push_back(mk(0,1, 9, 'h91,  0, 0,0,  1,0, 0, 0,    0,0, 0, 0, 1));
        vecs.push_back(mk(0,1, 10,'h92,  0, 0,0,  1,0, 9, 'h91, 0,0, 0, 0, 0));
        vecs.push_back(mk(0,1, 11,'h93,  0, 0,0,  1,0, 9, 'h91, 0,0, 0, 0, 0));
        vecs.push_back(mk(1,1, 12,'hC0,  0, 9,0,  1,0, 9, 'h91, 1,0, 'h91, 0, 0));
        vecs.push_back(mk(0,0, 0, 0,     1, 9,12, 1,0, 0, 0,    0,0, 0, 0, 1));
        vecs.push_back(mk(0,0, 0, 0,     1, 10,11,1,0, 0, 0,    0,0, 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].ev, vecs[i].er, vecs[i].ed, vecs[i].rf,
                  vecs[i].q1, vecs[i].q2);
            #1;
            chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // preload two entries, then enqueue and pop together past several wraps
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 5'(20 + k), 32'hA020 + 32'(k), 1'b0, 5'd0, 5'd0);
            mq.push_back({5'(20 + k), 32'hA020 + 32'(k)});
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 5'(1 + k), 32'hB000 + 32'(k), 1'b1, 5'd0, 5'd0);
            #1;
            chk($sformatf("wrap%0d", k),
                106'({enq_ready, reg_write, empty, wr_reg, wr_data}),
                106'({3'b110, mq[0]}));
            void'(mq.pop_front());
            mq.push_back({5'(1 + k), 32'hB000 + 32'(k)});
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
            #1;
            chk($sformatf("tail_drain%0d", k),
                106'({reg_write, empty, wr_reg, wr_data}),
                106'({2'b10, mq[0]}));
            void'(mq.pop_front());
        end
        @(negedge clk);
        #1;
        chk("wrap_empty", 106'({reg_write, empty}), 106'(2'b01));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_wb_queue.md
Name: rf_wb_queue

Overview:
- Writer-side companion to the CPU register file. Accepts writeback requests (destination register plus data) from execute and load units. Buffers them in a small in-order FIFO and drains one per cycle into the register file's single write port.
- Provides a two-port pending-write lookup. Decode can detect and forward values that are queued but not yet written.
- Sits between the writeback mux and the register file write inputs.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- PTR_W, 2, pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- enq_valid  input  1  writeback request present.
- enq_ready  output  1  queue can accept a request this cycle.
- enq_reg  input  5  destination register index.
- enq_data  input  32  writeback value.
- rf_ready  input  1  register file write port is free this cycle.
- reg_write  output  1  register file write enable.
- wr_reg  output  5  register file write index.
- wr_data  output  32  register file write data.
- q_reg1  input  5  lookup index, port 1.
- q_reg2  input  5  lookup index, port 2.
- hit1  output  1  a queued write targets q_reg1.
- hit2  output  1  a queued write targets q_reg2.
- fwd1  output  32  youngest queued value for q_reg1.
- fwd2  output  32  youngest queued value for q_reg2.
- empty  output  1  queue holds no entries.

Behaviour:
- Reset and clock: one clock, clk. Reset is synchronous and active-high on rst. When rst is sampled high, clear the following:
  - head and tail pointers and count;
  - all valid bits (entry contents are don't-care).
- Outputs after reset: reg_write=0, wr_reg=0, wr_data=0, hit1=hit2=0, fwd1=fwd2=0, empty=1, enq_ready=1.
- Reset mid-operation: all queued writes are discarded, never written to the register file. rst overrides any enqueue or drain in the same cycle.
- Storage: circular buffer of DEPTH entries, each {valid, reg[4:0], data[31:0]}. Pointers wrap from DEPTH-1 to 0. count ranges 0..DEPTH.
- Enqueue rules:
  - Handshake: enq_ready = (count != DEPTH), with no dependence on same-cycle drain. Accept when enq_valid && enq_ready.
  - Accepted request with enq_reg != 0: written at tail, tail advances, count increments.
  - Accepted request with enq_reg == 0: handshake completes but nothing is stored; pointers and count are unchanged.
  - enq_valid while full: no state change; the requester holds its request.
- Drain rules:
  - Outputs are combinational from the head entry.
  - reg_write = !empty && rf_ready.
  - wr_reg and wr_data = head entry fields when !empty, else 0.
  - When reg_write=1, the head pops at the clock edge: valid cleared, head advances, count decrements.
  - Latency: an entry accepted in cycle N is presented on wr_* from cycle N+1 at the earliest; there is no same-cycle bypass from the enq inputs to the wr outputs.
- Simultaneous enqueue and pop: both take effect and count is unchanged. When full, a pop does not raise enq_ready in the same cycle.
- Ordering: strict FIFO. Multiple entries to the same register are retained and drained in order, so the last write wins in the register file.
- Lookup (combinational, per port):
  - hitN = OR over valid entries with reg == q_regN.
  - fwdN = data of the youngest matching entry (closest to tail), else 0.
  - q_regN == 0 always gives hit=0, fwd=0.
  - The entry being popped this cycle still counts as a hit.
  - Enqueue inputs in the current cycle are not visible to lookup.
- Arithmetic: count is PTR_W+1 bits. Full is count==DEPTH; empty is count==0.

Test Plan:
- Reset, then enqueue (reg 5, 0x0000_00AA) with rf_ready=1: cycle 1 shows reg_write=1, wr_reg=5, wr_data=0xAA; cycle 2 shows empty=1 and reg_write=0.
- rf_ready=0, enqueue regs 1,2,3,4 with data 0x11..0x44: enq_ready=0 after the 4th. A 5th request (reg 6) is held with no state change. Then set rf_ready=1: drains in order 1,2,3,4 on consecutive cycles; enq_ready returns to 1 the cycle after the first pop.
- rf_ready=0, enqueue (7, 0xA), (7, 0xB), (3, 0xC); set q_reg1=7, q_reg2=0: hit1=1, fwd1=0xB, hit2=0, fwd2=0. After draining, the register file receives 0xA and then 0xB for reg 7.
- Enqueue (0, 0xDEAD): enq_ready handshake completes, count stays 0, reg_write never asserts.
- With 2 entries queued and rf_ready=1, present an enqueue in the same cycle as a pop: count stays 2. Continue across at least 2·DEPTH operations to show pointer wrap-around with no lost or reordered data.
- With 3 entries queued, assert rst for one cycle together with enq_valid=1: next cycle empty=1, reg_write=0, hit1=hit2=0; the discarded entries never appear on wr_*.
